// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and the round-robin search helper for the register write arbiter.
package reg_write_arbiter_pkg;

    localparam int unsigned MAX_NREQ = 32;
    localparam int unsigned MAX_IDW  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    typedef struct packed {
        logic               found;
        logic [MAX_IDW-1:0] id;
    } rr_pick_t;

    // First set request at or after ptr+1, wrapping at nreq (ptr < nreq assumed).
    function automatic rr_pick_t rr_search(input logic [MAX_IDW-1:0]  ptr,
                                           input logic [MAX_NREQ-1:0] req,
                                           input int unsigned         nreq);
        rr_pick_t    pick;
        int unsigned idx;
        pick = '0;
        for (int unsigned k = 1; k <= MAX_NREQ; k++) begin
            if (k <= nreq && !pick.found) begin
                idx = 32'(ptr) + k;
                if (idx >= nreq) begin
                    idx = idx - nreq;
                end
                if (req[MAX_IDW'(idx)]) begin
                    pick.found = 1'b1;
                    pick.id    = MAX_IDW'(idx);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_shared_reg.sv
// The shared WIDTH-bit register: async active-low clear, load on en.
module shared_reg #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting bounded, lockable ownership of one shared register.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter  int unsigned NREQ     = 4,
    parameter  int unsigned WIDTH    = 24,
    parameter  int unsigned MAX_LOCK = 4,
    localparam int unsigned IDW      = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  busy,
    output logic [IDW-1:0]        owner,
    output logic [WIDTH-1:0]      q
);

    localparam int unsigned CW = $clog2(MAX_LOCK + 1);

    state_t           state, state_d;
    logic [NREQ-1:0]  gnt_d;
    logic             busy_d;
    logic [IDW-1:0]   owner_d;
    logic [IDW-1:0]   rr_ptr, rr_ptr_d;
    logic [CW-1:0]    lock_cnt, lock_cnt_d;
    logic             load;
    rr_pick_t         pick;
    logic [WIDTH-1:0] data_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign data_arr[i] = data_in[i*WIDTH +: WIDTH];
    end

    // Only the current owner can be acknowledged; gnt is zero outside OWN.
    assign ack = gnt & req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            gnt      <= '0;
            busy     <= 1'b0;
            owner    <= '0;
            rr_ptr   <= IDW'(NREQ - 1);
            lock_cnt <= '0;
        end else begin
            state    <= state_d;
            gnt      <= gnt_d;
            busy     <= busy_d;
            owner    <= owner_d;
            rr_ptr   <= rr_ptr_d;
            lock_cnt <= lock_cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        gnt_d      = gnt;
        busy_d     = busy;
        owner_d    = owner;
        rr_ptr_d   = rr_ptr;
        lock_cnt_d = lock_cnt;
        load       = 1'b0;
        pick       = rr_search(MAX_IDW'(rr_ptr), MAX_NREQ'(req), NREQ);

        case (state)
            IDLE: begin
                if (pick.found) begin
                    state_d             = OWN;
                    gnt_d               = '0;
                    gnt_d[IDW'(pick.id)] = 1'b1;
                    busy_d              = 1'b1;
                    owner_d             = IDW'(pick.id);
                    lock_cnt_d          = '0;
                end
            end
            OWN: begin
                if (req[owner]) begin
                    load = 1'b1;
                end
                // Release on dropped request, unlocked write, or lock budget spent.
                if (!req[owner] || !lock[owner] || lock_cnt == CW'(MAX_LOCK - 1)) begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    busy_d     = 1'b0;
                    owner_d    = '0;
                    rr_ptr_d   = owner;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    shared_reg #(
        .WIDTH(WIDTH)
    ) u_shared_reg (
        .clk  (clk),
        .reset(reset),
        .en   (load),
        .d    (data_arr[owner]),
        .q    (q)
    );

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Table-driven bench for reg_write_arbiter with a write-data scoreboard on q.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [95:0] data_in;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        busy;
    logic [1:0]  owner;
    logic [23:0] q;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [95:0] din;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic        busy;
        logic [1:0]  owner;
        logic        wr;
        logic [23:0] wdata;
    } vec_t;

    vec_t        vecs[$];
    logic [23:0] sb_q[$];
    logic [23:0] exp_q;

    reg_write_arbiter #(
        .NREQ(4), .WIDTH(24), .MAX_LOCK(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .lock   (lock),
        .data_in(data_in),
        .gnt    (gnt),
        .ack    (ack),
        .busy   (busy),
        .owner  (owner),
        .q      (q)
    );

    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [95:0] mkd(input logic [23:0] d0, d1, d2, d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic add(input logic [3:0] r, input logic [3:0] l, input logic [95:0] d,
                       input logic [3:0] g, input logic [3:0] a, input logic b,
                       input logic [1:0] o);
        vec_t v;
        v.req = r; v.lock = l; v.din = d;
        v.gnt = g; v.ack = a; v.busy = b; v.owner = o;
        v.wr = |a;
        v.wdata = d[o*24 +: 24];
        vecs.push_back(v);
    endtask

    task automatic check_q();
        if (sb_q.size() > 0) begin
            exp_q = sb_q.pop_front();
        end
        chk("q", 32'(q), 32'(exp_q));
    endtask

    initial begin
        logic [95:0] d3, d2;
        reset = 1'b0; req = '0; lock = '0; data_in = '0; exp_q = '0;

        d3 = mkd(24'h000011, 24'h000022, 24'h000033, 24'h000044);
        d2 = mkd(24'h0, 24'hABCDEF, 24'h0, 24'h0);

        // Idle after reset
        for (int i = 0; i < 10; i++) add(4'b0000, 4'b0000, '0, 4'b0000, 4'b0000, 1'b0, 2'd0);

        // All requesting, unlocked: strict rotation with bubbles
        add(4'b1111, 4'b0000, d3, 4'b0000, 4'b0000, 1'b0, 2'd0);
        add(4'b1111, 4'b0000, d3, 4'b0001, 4'b0001, 1'b1, 2'd0);
        add(4'b1111, 4'b0000, d3, 4'b0000, 4'b0000, 1'b0, 2'd0);
        add(4'b1111, 4'b0000, d3, 4'b0010, 4'b0010, 1'b1, 2'd1);
        add(4'b1111, 4'b0000, d3, 4'b0000, 4'b0000, 1'b0, 2'd0);
        add(4'b1111, 4'b0000, d3, 4'b0100, 4'b0100, 1'b1, 2'd2);
        add(4'b1111, 4'b0000, d3, 4'b0000, 4'b0000, 1'b0, 2'd0);
        add(4'b1111, 4'b0000, d3, 4'b1000, 4'b1000, 1'b1, 2'd3);
        add(4'b1111, 4'b0000, d3, 4'b0000, 4'b0000, 1'b0, 2'd0);
        add(4'b1111, 4'b0000, d3, 4'b0001, 4'b0001, 1'b1, 2'd0);
        add(4'b0000, 4'b0000, d3, 4'b0000, 4'b0000, 1'b0, 2'd0);

        // Single write by requester 1
        add(4'b0010, 4'b0000, d2, 4'b0000, 4'b0000, 1'b0, 2'd0);
        add(4'b0010, 4'b0000, d2, 4'b0010, 4'b0010, 1'b1, 2'd1);
        add(4'b0000, 4'b0000, d2, 4'b0000, 4'b0000, 1'b0, 2'd0);
        add(4'b0000, 4'b0000, d2, 4'b0000, 4'b0000, 1'b0, 2'd0);

        // Locked owner 2: four writes, forced release, then requester 0
        add(4'b0101, 4'b0100, mkd(24'h0000B0, 0, 24'h200000, 0), 4'b0000, 4'b0000, 1'b0, 2'd0);
        for (int i = 1; i <= 4; i++)
            add(4'b0101, 4'b0100, mkd(24'h0000B0, 0, 24'h200000 + 24'(i), 0),
                4'b0100, 4'b0100, 1'b1, 2'd2);
        add(4'b0101, 4'b0100, mkd(24'h0000B0, 0, 24'h200009, 0), 4'b0000, 4'b0000, 1'b0, 2'd0);
        add(4'b0101, 4'b0100, mkd(24'h0000B0, 0, 24'h200009, 0), 4'b0001, 4'b0001, 1'b1, 2'd0);
        add(4'b0000, 4'b0000, '0, 4'b0000, 4'b0000, 1'b0, 2'd0);

        // Locked owner 3 drops req after two writes
        add(4'b1000, 4'b1000, mkd(0, 0, 0, 24'hC00001), 4'b0000, 4'b0000, 1'b0, 2'd0);
        add(4'b1000, 4'b1000, mkd(0, 0, 0, 24'hC00001), 4'b1000, 4'b1000, 1'b1, 2'd3);
        add(4'b1000, 4'b1000, mkd(0, 0, 0, 24'hC00002), 4'b1000, 4'b1000, 1'b1, 2'd3);
        add(4'b0000, 4'b1000, mkd(0, 0, 0, 24'hC00003), 4'b1000, 4'b0000, 1'b1, 2'd3);
        add(4'b0000, 4'b0000, mkd(0, 0, 0, 24'hC00003), 4'b0000, 4'b0000, 1'b0, 2'd0);

        #12;
        chk("reset_q", 32'(q), 32'h0);
        chk("reset_gnt", 32'(gnt), 32'h0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            req = vecs[i].req; lock = vecs[i].lock; data_in = vecs[i].din;
            #1;
            chk($sformatf("gnt[%0d]", i), 32'(gnt), 32'(vecs[i].gnt));
            chk($sformatf("ack[%0d]", i), 32'(ack), 32'(vecs[i].ack));
            chk($sformatf("busy[%0d]", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("owner[%0d]", i), 32'(owner), 32'(vecs[i].owner));
            if (vecs[i].wr) sb_q.push_back(vecs[i].wdata);
            @(posedge clk);
            #1;
            check_q();
        end

        // Reset asserted mid-ownership with a write pending
        @(negedge clk);
        req = 4'b0010; lock = 4'b0010; data_in = mkd(24'h3D00AA, 24'h3D0001, 0, 0);
        #1 chk("rst_seq_idle", 32'(busy), 32'h0);
        @(posedge clk);
        @(negedge clk);
        req = 4'b0011;
        #1 chk("rst_seq_gnt1", 32'(gnt), 32'h2);
        chk("rst_seq_ack1", 32'(ack), 32'h2);
        sb_q.push_back(24'h3D0001);
        @(posedge clk);
        #1 check_q();
        @(negedge clk);
        data_in = mkd(24'h3D00AA, 24'h3D0002, 0, 0);
        #1 chk("rst_seq_gnt_held", 32'(gnt), 32'h2);
        reset = 1'b0;
        #1;
        chk("rst_mid_q", 32'(q), 32'h0);
        chk("rst_mid_gnt", 32'(gnt), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_owner", 32'(owner), 32'h0);
        exp_q = '0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check_q();
        chk("post_rst_gnt", 32'(gnt), 32'h1);
        chk("post_rst_owner", 32'(owner), 32'h0);
        @(negedge clk);
        #1 chk("post_rst_ack", 32'(ack), 32'h1);
        sb_q.push_back(24'h3D00AA);
        @(posedge clk);
        #1 check_q();
        chk("post_rst_release", 32'(busy), 32'h0);
        @(negedge clk);
        req = '0; lock = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
